// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - write-op encoding and write-value helper shared by the register file
package regfile_pkg;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_ONE  = 2'b01;
    localparam logic [1:0] WR_ZERO = 2'b10;
    localparam logic [1:0] WR_DATA = 2'b11;

    // Widest register the helper can serve; callers zero-extend in and truncate out.
    localparam int MAX_DATA_W = 128;

    function automatic logic [MAX_DATA_W-1:0] wrValue(
        input logic [1:0]            op,
        input logic [MAX_DATA_W-1:0] data
    );
        case (op)
            WR_ONE:  wrValue = MAX_DATA_W'(1);
            WR_ZERO: wrValue = '0;
            WR_DATA: wrValue = data;
            default: wrValue = '0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_sb_board.sv
// rtl/regfile_sb_board.sv - per-register busy scoreboard, outstanding-producer count, sticky error
module regfile_sb_board
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 1
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 iss_vld,
    input  logic [ADDR_W-1:0]    iss_addr,
    input  logic [1:0]           wr_op,
    input  logic [ADDR_W-1:0]    wr_addr,
    output logic [2**ADDR_W-1:0] busy,
    output logic [ADDR_W:0]      busy_cnt,
    output logic                 sb_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic             issEff;
    logic             wrEff;
    logic             sameAddr;
    logic             cntInc;
    logic             cntDec;
    logic             errSet;
    logic [DEPTH-1:0] busyNext;

    always_comb begin
        issEff   = iss_vld && !((ZERO_R0 != 0) && (iss_addr == '0));
        wrEff    = (wr_op != WR_NONE) && !((ZERO_R0 != 0) && (wr_addr == '0));
        sameAddr = issEff && (iss_addr == wr_addr);

        // Issue applied after the clear so a newer producer on the same register wins.
        busyNext = busy;
        if (wrEff) begin
            busyNext[wr_addr] = 1'b0;
        end
        if (issEff) begin
            busyNext[iss_addr] = 1'b1;
        end

        // Inc and dec can only coincide on different registers, so the net step stays within +-1.
        cntInc = issEff && !busy[iss_addr];
        cntDec = wrEff && busy[wr_addr] && !sameAddr;
        errSet = wrEff && !busy[wr_addr] && !sameAddr;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            busy     <= '0;
            busy_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            busy <= busyNext;
            if (cntInc && !cntDec) begin
                busy_cnt <= busy_cnt + (ADDR_W+1)'(1);
            end else if (cntDec && !cntInc) begin
                busy_cnt <= busy_cnt - (ADDR_W+1)'(1);
            end
            if (errSet) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with RAW scoreboard and decode stall
// Optional REGFILE_SB_BYPASS_EN: same-cycle write-to-read forwarding of data and busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int N_RD    = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_busy,
    output logic                     stall,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [1:0]               wr_op,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_vld,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          busy_cnt,
    output logic                     sb_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busyVec;
    logic [DATA_W-1:0] wrVal;
    logic              wrHit;
    logic [ADDR_W-1:0] addrK;
    logic [DATA_W-1:0] dataK;
    logic              busyK;

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    assign wrVal = DATA_W'(wrValue(wr_op, MAX_DATA_W'(wr_data)));
    assign wrHit = (wr_op != WR_NONE) && !isZeroReg(wr_addr);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrHit) begin
            regs[wr_addr] <= wrVal;
        end
    end

    regfile_sb_board #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_board (
        .clk      (clk),
        .rst_     (rst_),
        .iss_vld  (iss_vld),
        .iss_addr (iss_addr),
        .wr_op    (wr_op),
        .wr_addr  (wr_addr),
        .busy     (busyVec),
        .busy_cnt (busy_cnt),
        .sb_err   (sb_err)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        addrK   = '0;
        dataK   = '0;
        busyK   = 1'b0;
        for (int k = 0; k < N_RD; k++) begin
            addrK = rd_addr[k*ADDR_W +: ADDR_W];
            dataK = regs[addrK];
            busyK = busyVec[addrK];
`ifdef REGFILE_SB_BYPASS_EN
            // A retiring write is visible now; only a same-cycle reissue keeps the operand busy.
            if (wrHit && (addrK == wr_addr)) begin
                dataK = wrVal;
                busyK = iss_vld && (iss_addr == addrK);
            end
`endif
            if (isZeroReg(addrK)) begin
                dataK = '0;
                busyK = 1'b0;
            end
            rd_data[k*DATA_W +: DATA_W] = dataK;
            rd_busy[k]                  = busyK;
        end
    end

    assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed stimulus with a queued-expectation scoreboard for regfile_sb
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int SEL_D0 = 0, SEL_D1 = 1, SEL_BUSY = 2, SEL_STALL = 3, SEL_CNT = 4, SEL_ERR = 5;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic [1:0]  rd_en;
    logic [1:0]  wr_op;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_vld;
    logic [3:0]  iss_addr;
    logic [4:0]  busy_cnt;
    logic        sb_err;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        q[$];
    chk_t        cur;
    logic [31:0] act;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_W (32),
        .ADDR_W (4),
        .N_RD   (2),
        .ZERO_R0(1)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .stall    (stall),
        .rd_en    (rd_en),
        .wr_op    (wr_op),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_vld  (iss_vld),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt),
        .sb_err   (sb_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [3:0] ia, input logic [1:0] op,
                         input logic [3:0] wa, input logic [31:0] wd);
        iss_vld  = iv;
        iss_addr = ia;
        wr_op    = op;
        wr_addr  = wa;
        wr_data  = wd;
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] en);
        rd_addr = {a1, a0};
        rd_en   = en;
    endtask

    task automatic chk(input string n, input int s, input logic [31:0] e);
        q.push_back('{n, s, e});
    endtask

    // Outputs are checked mid-cycle, away from the active edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            cur = q.pop_front();
            case (cur.sel)
                SEL_D0:    act = rd_data[31:0];
                SEL_D1:    act = rd_data[63:32];
                SEL_BUSY:  act = {30'd0, rd_busy};
                SEL_STALL: act = {31'd0, stall};
                SEL_CNT:   act = {27'd0, busy_cnt};
                default:   act = {31'd0, sb_err};
            endcase
            compared++;
            if (act !== cur.exp) begin
                mismatched++;
                $display("FAIL %s: actual %h required %h", cur.name, act, cur.exp);
            end
        end
    end

    initial begin
        drive(0, 0, 2'b00, 0, 0);
        rd(0, 0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", SEL_D0, 0);
        chk("rst_busy", SEL_BUSY, 0);
        chk("rst_stall", SEL_STALL, 0);
        chk("rst_cnt", SEL_CNT, 0);
        chk("rst_err", SEL_ERR, 0);

        // Mid-run asynchronous reset
        step(); rst_ = 1'b1; drive(1, 5, 2'b00, 0, 0);
        step(); drive(1, 6, 2'b11, 5, 32'hDEADBEEF); rd(5, 0, 2'b00);
        step(); drive(0, 0, 2'b11, 8, 32'h55);
        chk("t1_data", SEL_D0, 32'hDEADBEEF);
        chk("t1_cnt", SEL_CNT, 1);
        chk("t1_err0", SEL_ERR, 0);
        step(); drive(0, 0, 2'b00, 0, 0);
        chk("t1_err1", SEL_ERR, 1);
        step(); rst_ = 1'b0;
        chk("t1_rst_data", SEL_D0, 0);
        chk("t1_rst_cnt", SEL_CNT, 0);
        chk("t1_rst_err", SEL_ERR, 0);

        // Write-op sequence on r3
        step(); rst_ = 1'b1; drive(1, 3, 2'b00, 0, 0); rd(3, 0, 2'b01);
        step(); drive(0, 0, 2'b11, 3, 32'h12345678);
        chk("t2_busy", SEL_BUSY, BYP ? 32'd0 : 32'd1);
        chk("t2_stall", SEL_STALL, BYP ? 32'd0 : 32'd1);
        chk("t2_data_wr", SEL_D0, BYP ? 32'h12345678 : 32'd0);
        step(); drive(0, 0, 2'b01, 3, 32'hFFFFFFFF);
        chk("t2_data", SEL_D0, BYP ? 32'd1 : 32'h12345678);
        chk("t2_busy0", SEL_BUSY, 0);
        step(); drive(0, 0, 2'b10, 3, 32'hFFFFFFFF);
        chk("t2_one", SEL_D0, BYP ? 32'd0 : 32'd1);
        step(); drive(0, 0, 2'b00, 0, 0);
        chk("t2_zero", SEL_D0, 0);
        chk("t2_err", SEL_ERR, 1);

        // RAW stall on r7
        step(); drive(1, 7, 2'b00, 0, 0); rd(7, 0, 2'b01);
        step(); drive(0, 0, 2'b00, 0, 0);
        chk("t3_stall_a", SEL_STALL, 1);
        step();
        chk("t3_stall_b", SEL_STALL, 1);
        step(); drive(0, 0, 2'b11, 7, 32'hCAFE);
        chk("t3_stall_wr", SEL_STALL, BYP ? 32'd0 : 32'd1);
        chk("t3_data_wr", SEL_D0, BYP ? 32'hCAFE : 32'd0);
        step(); drive(0, 0, 2'b00, 0, 0);
        chk("t3_stall_end", SEL_STALL, 0);
        chk("t3_data", SEL_D0, 32'hCAFE);

        // Issue and write to r4 in the same cycle
        step(); drive(1, 4, 2'b00, 0, 0); rd(4, 0, 2'b01);
        step(); drive(1, 4, 2'b11, 4, 32'hA5);
        chk("t4_cnt_before", SEL_CNT, 1);
        chk("t4_busy_wr", SEL_BUSY, 1);
        chk("t4_data_wr", SEL_D0, BYP ? 32'hA5 : 32'd0);
        step(); drive(0, 0, 2'b00, 0, 0);
        chk("t4_data", SEL_D0, 32'hA5);
        chk("t4_busy", SEL_BUSY, 1);
        chk("t4_cnt", SEL_CNT, 1);
        chk("t4_stall", SEL_STALL, 1);

        // Hardwired zero register
        step(); rst_ = 1'b0;
        step(); rst_ = 1'b1; drive(1, 0, 2'b11, 0, 32'hFFFF); rd(0, 0, 2'b01);
        chk("t5_data_wr", SEL_D0, 0);
        chk("t5_busy_wr", SEL_BUSY, 0);
        chk("t5_stall_wr", SEL_STALL, 0);
        step(); drive(1, 1, 2'b00, 0, 0);
        chk("t5_data", SEL_D0, 0);
        chk("t5_busy", SEL_BUSY, 0);
        chk("t5_cnt", SEL_CNT, 0);
        chk("t5_err", SEL_ERR, 0);

        // Scoreboard bookkeeping
        step(); drive(1, 2, 2'b00, 0, 0);
        chk("t6_cnt1", SEL_CNT, 1);
        step(); drive(1, 3, 2'b00, 0, 0);
        chk("t6_cnt2", SEL_CNT, 2);
        step(); drive(0, 0, 2'b11, 9, 32'h99); rd(0, 9, 2'b00);
        chk("t6_cnt3", SEL_CNT, 3);
        chk("t6_err0", SEL_ERR, 0);
        chk("t6_byp_r9", SEL_D1, BYP ? 32'h99 : 32'd0);
        step(); drive(0, 0, 2'b11, 1, 32'h11);
        chk("t6_err1", SEL_ERR, 1);
        chk("t6_cnt_hold", SEL_CNT, 3);
        chk("t6_r9", SEL_D1, 32'h99);
        step(); drive(0, 0, 2'b00, 0, 0); rd(2, 1, 2'b00);
        chk("t6_cnt_dec", SEL_CNT, 2);
        chk("t6_err_sticky", SEL_ERR, 1);
        chk("t6_r1", SEL_D1, 32'h11);
        chk("t6_busy_ports", SEL_BUSY, 1);
        chk("t6_stall_masked", SEL_STALL, 0);

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: actual %0d pending required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's 16x32 register file, used by the RISC-V datapath's decode and write-back stages.
- Width, depth and read-port count are generic.
- Keeps the write/set-to-1/clear-to-0 write opcode.
- Adds hardwired-zero register 0 and a per-register busy scoreboard.
- The scoreboard gives decode a stall signal for RAW hazards on in-flight writes and a count of outstanding producers.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W
N_RD, 2, number of read ports (1..4)
ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes, issue and busy

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  asynchronous active-low reset
rd_addr  in  N_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  N_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  N_RD  per-port busy flag of addressed register
stall  out  1  OR of rd_busy over ports enabled by rd_en
rd_en  in  N_RD  per-port "operand used" qualifiers for stall
wr_op  in  2  00 none, 01 write 1, 10 write 0, 11 write wr_data
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
iss_vld  in  1  instruction issued with a destination register
iss_addr  in  ADDR_W  destination of issued instruction
busy_cnt  out  ADDR_W+1  number of registers currently busy
sb_err  out  1  sticky: write op to a non-busy register (ZERO_R0 reg excluded)

Behaviour:
- Reset (rst_ low, asynchronous):
  - all registers 0, all busy bits 0, busy_cnt 0, sb_err 0;
  - rd_data therefore reads 0, rd_busy 0, stall 0.
- Reads are combinational from array state: rd_data = RF[rd_addr], rd_busy = busy[rd_addr].
- Writes take effect at posedge clk, new value visible the following cycle (without the optional feature).
  - wr_op 11: RF <= wr_data.
  - wr_op 01: RF <= 1 (zero-extended to DATA_W).
  - wr_op 10: RF <= 0.
  - wr_op 00: no write.
  - No #delays anywhere.
- ZERO_R0=1: register 0 always reads 0 and rd_busy 0; writes and issues to address 0 are dropped.
- Busy bit per register, updated at posedge:
  - iss_vld sets busy[iss_addr];
  - any wr_op != 00 clears busy[wr_addr].
  - Same cycle, same address, issue and write both present: issue wins; busy stays 1 (newer producer outstanding) and the data write still happens.
  - Issue to an already-busy register: busy stays 1 (WAW allowed; the single bit tracks "some producer pending").
- busy_cnt: registered count of set busy bits, updated in the same edge as the busy vector.
  - Net change per cycle is -1, 0 or +1.
  - Never wraps; max 2**ADDR_W.
- sb_err: set at posedge when wr_op != 00 and busy[wr_addr] == 0 and no same-cycle iss_vld to that address; cleared only by reset.
- stall = OR over k of (rd_en[k] & rd_busy[k]). Combinational, no registered delay.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: write-to-read forwarding. When wr_op != 00 and rd_addr[k] == wr_addr in the same cycle:
  - rd_data[k] returns the value being written (wr_data, 1 or 0 per op);
  - rd_busy[k] reads 0 unless iss_vld to the same address is also present.
  - Gives zero-latency write-back visibility.
- Undefined: reads see the old value and old busy until the next cycle.
- ZERO_R0 still forces 0 on address 0 in both cases.

Decomposition:
- Shared package regfile_pkg:
  - wr_op encoding localparams WR_NONE=2'b00, WR_ONE=2'b01, WR_ZERO=2'b10, WR_DATA=2'b11;
  - a function computing write value from op and data.
- One sub-module, regfile_sb_board: busy vector, busy_cnt, sb_err.
- Data array and read muxes/bypass stay in the top.

Test Plan:
1. Reset mid-run after writing 0xDEADBEEF to r5: assert rst_ low between edges -> rd_data for r5 = 0 immediately, busy_cnt 0, sb_err 0.
2. Write-op sequence on r3:
   - iss r3, then wr_op 11 data 0x12345678 -> next cycle r3 = 0x12345678, busy 0;
   - wr_op 01 -> r3 = 1;
   - wr_op 10 -> r3 = 0.
3. RAW stall: iss_vld r7, rd_addr port0=7 with rd_en=01 -> stall=1 from next cycle until the cycle after wr_op 11 to r7. With REGFILE_SB_BYPASS_EN, stall drops in the write cycle and rd_data shows wr_data.
4. Simultaneous iss_vld r4 and wr_op 11 r4 data 0xA5 -> r4 = 0xA5, busy[4] stays 1, busy_cnt unchanged.
5. Zero register (ZERO_R0=1): iss r0 plus wr_op 11 r0 data 0xFFFF -> rd_data 0, rd_busy 0, busy_cnt 0, sb_err 0.
6. Scoreboard bookkeeping:
   - issue r1, r2, r3 on consecutive cycles -> busy_cnt 1, 2, 3;
   - write r9 while not busy -> sb_err = 1 and stays 1 until reset.
